// File: rtl/seq_match_pkg.sv
// Shared types and sizing for the serial pattern-match controller.
// Holds the controller state enum and the default widths used by every file.
package seq_match_pkg;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/seq_match_ctrl_pattern_matcher.sv
// Serial history shift register with a length-masked compare against the pattern.
// o_match already includes the bit being shifted in this cycle.
module pattern_matcher
    import seq_match_pkg::*;
#(
    parameter int MAX_LEN = seq_match_pkg::MAX_LEN
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic               i_bit,
    input  logic               i_overlap,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_match
);

    logic [MAX_LEN-1:0] r_history;
    logic [LEN_W-1:0]   r_bitsSeen;
    logic [MAX_LEN-1:0] w_nextHistory;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_nextSeen;

    // A length of MAX_LEN wraps the shifted one to zero, so the subtraction yields all ones.
    always_comb begin
        w_nextHistory = {r_history[MAX_LEN-2:0], i_bit};
        w_nextSeen    = (r_bitsSeen >= i_len) ? i_len : r_bitsSeen + LEN_W'(1);
        w_mask        = (MAX_LEN'(1) << i_len) - MAX_LEN'(1);
        o_match       = i_shift && (w_nextSeen >= i_len) &&
                        ((w_nextHistory & w_mask) == (i_pattern & w_mask));
    end

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_history  <= '0;
            r_bitsSeen <= '0;
        end else if (i_shift) begin
            r_history  <= w_nextHistory;
            r_bitsSeen <= (o_match && !i_overlap) ? '0 : w_nextSeen;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Serial sequence-match controller: configuration handshake, run FSM and match counter.
// The bit history and compare live in pattern_matcher.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int MAX_LEN = seq_match_pkg::MAX_LEN,
    parameter int CNT_W   = seq_match_pkg::CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               cfg_overlap,
    input  logic               start,
    input  logic               abort,
    input  logic               data_in,
    input  logic               data_valid,
    output logic               detect,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_target;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_count;
    logic               r_detect;
    logic               r_cfgErr;
    logic               r_busy;
    logic               r_done;
    logic               r_cfgReady;

    logic               w_cfgLegal;
    logic               w_startGo;
    logic               w_shift;
    logic               w_match;
    logic [CNT_W-1:0]   w_countInc;

    // In DONE a simultaneous configuration offer wins over start.
    assign w_cfgLegal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign w_startGo  = !abort && start &&
                        ((r_state == S_ARMED) || ((r_state == S_DONE) && !cfg_valid));
    assign w_shift    = !abort && (r_state == S_RUN) && data_valid;
    assign w_countInc = (&r_count) ? r_count : r_count + CNT_W'(1);

    pattern_matcher #(
        .MAX_LEN (MAX_LEN)
    ) u_matcher (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_startGo),
        .i_shift   (w_shift),
        .i_bit     (data_in),
        .i_overlap (r_overlap),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .o_match   (w_match)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pattern  <= '0;
            r_len      <= '0;
            r_target   <= '0;
            r_overlap  <= 1'b0;
            r_count    <= '0;
            r_detect   <= 1'b0;
            r_cfgErr   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cfgReady <= 1'b1;
        end else begin
            r_detect <= 1'b0;
            r_cfgErr <= 1'b0;
            if (abort) begin
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_cfgReady <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (cfg_valid) begin
                            if (w_cfgLegal) begin
                                r_pattern  <= cfg_pattern;
                                r_len      <= cfg_len;
                                r_target   <= cfg_target;
                                r_overlap  <= cfg_overlap;
                                r_state    <= S_ARMED;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b0;
                                r_cfgReady <= 1'b0;
                            end else begin
                                r_cfgErr <= 1'b1;
                            end
                        end else if (w_startGo) begin
                            r_count    <= '0;
                            r_state    <= S_RUN;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_cfgReady <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (w_startGo) begin
                            r_count    <= '0;
                            r_state    <= S_RUN;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_cfgReady <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (w_match) begin
                            r_detect <= 1'b1;
                            r_count  <= w_countInc;
                            if ((r_target != '0) && (w_countInc == r_target)) begin
                                r_state    <= S_DONE;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                                r_cfgReady <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b0;
                        r_cfgReady <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign cfg_ready   = r_cfgReady;
    assign detect      = r_detect;
    assign match_count = r_count;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cfg_err     = r_cfgErr;

endmodule
